// File: rtl/ahb_wb_arbiter_if.sv
// ahb_wb_arbiter_if
//   Bundles every bus signal around the AHB/sbus -> Wishbone arbiter.
//   slave  : the arbiter's view. It takes the AHB-Lite request, the debug
//            sbus request and the Wishbone slave response, and drives the
//            AHB response, the sbus response and the Wishbone master side.
//   master : the surrounding system's view (CPU, debug module and Wishbone
//            slave), with every direction reversed.
interface ahb_wb_arbiter_if;
   // AHB-Lite master request / response
   logic [31:0] haddr;
   logic        hwrite;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;
   // debug system bus request / response
   logic [31:0] sbus_addr;
   logic        sbus_write;
   logic [1:0]  sbus_size;
   logic [31:0] sbus_wdata;
   logic        sbus_vld;
   logic        sbus_rdy;
   logic        sbus_err;
   logic [31:0] sbus_rdata;
   // Wishbone classic master / slave response
   logic        core_cyc;
   logic        core_stb;
   logic        core_we;
   logic [31:0] core_addr;
   logic [3:0]  core_sel;
   logic [31:0] core_data_out;
   logic [31:0] core_data_in;
   logic        core_ack;

   modport slave (
      input  haddr, hwrite, htrans, hsize, hwdata,
      output hrdata, hready, hresp,
      input  sbus_addr, sbus_write, sbus_size, sbus_wdata, sbus_vld,
      output sbus_rdy, sbus_err, sbus_rdata,
      output core_cyc, core_stb, core_we, core_addr, core_sel, core_data_out,
      input  core_data_in, core_ack
   );

   modport master (
      output haddr, hwrite, htrans, hsize, hwdata,
      input  hrdata, hready, hresp,
      output sbus_addr, sbus_write, sbus_size, sbus_wdata, sbus_vld,
      input  sbus_rdy, sbus_err, sbus_rdata,
      input  core_cyc, core_stb, core_we, core_addr, core_sel, core_data_out,
      output core_data_in, core_ack
   );
endinterface

// File: rtl/ahb_wb_arbiter.sv
// ahb_wb_arbiter
//   Shares one Wishbone classic master port between the Hazard3 AHB-Lite
//   port and the Hazard3 debug system bus. Requests are granted round-robin,
//   one Wishbone cycle at a time, with byte selects and write-lane
//   replication generated from address and size. Misaligned or oversized
//   accesses and Wishbone cycles that are never acknowledged come back as
//   error responses.
// Ports
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : ahb_wb_arbiter_if.slave -- AHB request/response, sbus
//                request/response and Wishbone master/slave signals
// Parameters
//   TIMEOUT_CYCLES : cycles of an unacknowledged Wishbone cycle before it is
//                    abandoned with an error (minimum 2)
module ahb_wb_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic             clk,
   input logic             rst_n,
   ahb_wb_arbiter_if.slave bus
);
   localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic GNT_AHB  = 1'b0;
   localparam logic GNT_SBUS = 1'b1;

   typedef enum logic [1:0] {IDLE, BUS, ERR1, ERR2} state_t;

   state_t           state_q, state_d;
   logic             ahb_pend_q, ahb_pend_d;
   logic [31:0]      ahb_addr_q, ahb_addr_d;
   logic             ahb_write_q, ahb_write_d;
   logic [2:0]       ahb_size_q, ahb_size_d;
   logic             last_grant_q, last_grant_d;
   logic             owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hready_q, hready_d;
   logic             hresp_q, hresp_d;
   logic [31:0]      hrdata_q, hrdata_d;
   logic             sbus_rdy_q, sbus_rdy_d;
   logic             sbus_err_q, sbus_err_d;
   logic [31:0]      sbus_rdata_q, sbus_rdata_d;
   logic             cyc_q, cyc_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [3:0]       sel_q, sel_d;
   logic [31:0]      dout_q, dout_d;

   // Sizes above a word are rejected for both requesters.
   function automatic logic access_bad(input logic [1:0] a, input logic [2:0] size);
      case (size)
         3'd0:    access_bad = 1'b0;
         3'd1:    access_bad = a[0];
         3'd2:    access_bad = (a != 2'b00);
         default: access_bad = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] byte_sel(input logic [1:0] a, input logic [1:0] size);
      case (size)
         2'd0:    byte_sel = 4'b0001 << a;
         2'd1:    byte_sel = a[1] ? 4'b1100 : 4'b0011;
         default: byte_sel = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] size);
      case (size)
         2'd0:    lane_data = {4{d[7:0]}};
         2'd1:    lane_data = {2{d[15:0]}};
         default: lane_data = d;
      endcase
   endfunction

   logic        ahb_capture, sbus_pend, grant_sbus, req_bad, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_size;
   logic        unused_htrans0;

   assign unused_htrans0 = bus.htrans[0];
   assign ahb_capture    = hready_q & bus.htrans[1];
   // sbus_vld is still high in the cycle its response is delivered; masking
   // with sbus_rdy_q keeps that finished request from being granted again.
   assign sbus_pend      = bus.sbus_vld & ~sbus_rdy_q;
   assign grant_sbus     = sbus_pend & (~ahb_pend_q | (last_grant_q == GNT_AHB));
   assign req_addr       = grant_sbus ? bus.sbus_addr : ahb_addr_q;
   assign req_write      = grant_sbus ? bus.sbus_write : ahb_write_q;
   assign req_size       = grant_sbus ? {1'b0, bus.sbus_size} : ahb_size_q;
   // hwdata belongs to the data phase and is still valid at grant time.
   assign req_wdata      = grant_sbus ? bus.sbus_wdata : bus.hwdata;
   assign req_bad        = access_bad(req_addr[1:0], req_size);

   always_comb begin
      state_d      = state_q;
      ahb_pend_d   = ahb_pend_q;
      ahb_addr_d   = ahb_addr_q;
      ahb_write_d  = ahb_write_q;
      ahb_size_d   = ahb_size_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      hready_d     = hready_q;
      hresp_d      = hresp_q;
      hrdata_d     = hrdata_q;
      sbus_rdy_d   = 1'b0;
      sbus_err_d   = 1'b0;
      sbus_rdata_d = sbus_rdata_q;
      cyc_d        = cyc_q;
      we_d         = we_q;
      addr_d       = addr_q;
      sel_d        = sel_q;
      dout_d       = dout_q;

      case (state_q)
         IDLE: begin
            if (ahb_pend_q | sbus_pend) begin
               last_grant_d = grant_sbus;
               owner_d      = grant_sbus;
               if (!grant_sbus) ahb_pend_d = 1'b0;
               if (req_bad) begin
                  state_d = ERR1;
                  if (grant_sbus) begin
                     sbus_rdy_d = 1'b1;
                     sbus_err_d = 1'b1;
                  end else begin
                     hresp_d = 1'b1;
                  end
               end else begin
                  state_d = BUS;
                  cyc_d   = 1'b1;
                  we_d    = req_write;
                  addr_d  = {req_addr[31:2], 2'b00};
                  sel_d   = byte_sel(req_addr[1:0], req_size[1:0]);
                  dout_d  = lane_data(req_wdata, req_size[1:0]);
                  cnt_d   = '0;
               end
            end
         end
         BUS: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.core_ack) begin
               cyc_d   = 1'b0;
               state_d = IDLE;
               if (owner_q == GNT_SBUS) begin
                  sbus_rdy_d   = 1'b1;
                  sbus_rdata_d = bus.core_data_in;
               end else begin
                  hready_d = 1'b1;
                  hrdata_d = bus.core_data_in;
               end
            end else if (cnt_q == CNT_LAST) begin
               cyc_d   = 1'b0;
               state_d = ERR1;
               if (owner_q == GNT_SBUS) begin
                  sbus_rdy_d = 1'b1;
                  sbus_err_d = 1'b1;
               end else begin
                  hresp_d = 1'b1;
               end
            end
         end
         ERR1: begin
            // AHB needs the second error cycle; sbus finishes in this one.
            if (owner_q == GNT_AHB) begin
               hready_d = 1'b1;
               hresp_d  = 1'b1;
               state_d  = ERR2;
            end else begin
               state_d = IDLE;
            end
         end
         ERR2: begin
            hresp_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Any address phase seen with hready high is taken, including the one
      // overlapping a response, so AHB can issue back-to-back transfers.
      if (ahb_capture) begin
         ahb_pend_d  = 1'b1;
         ahb_addr_d  = bus.haddr;
         ahb_write_d = bus.hwrite;
         ahb_size_d  = bus.hsize;
         hready_d    = 1'b0;
         hresp_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ahb_pend_q   <= 1'b0;
         ahb_addr_q   <= '0;
         ahb_write_q  <= 1'b0;
         ahb_size_q   <= '0;
         last_grant_q <= GNT_AHB;
         owner_q      <= GNT_AHB;
         cnt_q        <= '0;
         hready_q     <= 1'b1;
         hresp_q      <= 1'b0;
         hrdata_q     <= '0;
         sbus_rdy_q   <= 1'b0;
         sbus_err_q   <= 1'b0;
         sbus_rdata_q <= '0;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         sel_q        <= '0;
         dout_q       <= '0;
      end else begin
         state_q      <= state_d;
         ahb_pend_q   <= ahb_pend_d;
         ahb_addr_q   <= ahb_addr_d;
         ahb_write_q  <= ahb_write_d;
         ahb_size_q   <= ahb_size_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         hready_q     <= hready_d;
         hresp_q      <= hresp_d;
         hrdata_q     <= hrdata_d;
         sbus_rdy_q   <= sbus_rdy_d;
         sbus_err_q   <= sbus_err_d;
         sbus_rdata_q <= sbus_rdata_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         sel_q        <= sel_d;
         dout_q       <= dout_d;
      end
   end

   assign bus.hready        = hready_q;
   assign bus.hresp         = hresp_q;
   assign bus.hrdata        = hrdata_q;
   assign bus.sbus_rdy      = sbus_rdy_q;
   assign bus.sbus_err      = sbus_err_q;
   assign bus.sbus_rdata    = sbus_rdata_q;
   assign bus.core_cyc      = cyc_q;
   assign bus.core_stb      = cyc_q;
   assign bus.core_we       = we_q;
   assign bus.core_addr     = addr_q;
   assign bus.core_sel      = sel_q;
   assign bus.core_data_out = dout_q;
endmodule

// File: doc/ahb_wb_arbiter.md
# ahb_wb_arbiter

Bridges the Hazard3 single-port AHB-Lite master and the Hazard3 debug system bus (sbus) onto the one Wishbone core bus served by the Controller (`core_*` signals). Arbitrates round-robin between the two requesters, converts AHB pipelined transfers and sbus valid/ready requests into single Wishbone classic cycles, and generates byte selects. Returns error responses on misaligned access and bus timeout. Sits between `cpu` and `u_Controller` inside `processorci_top`.

## Interface
- `TIMEOUT_CYCLES`, 1024: Wishbone cycles without `core_ack` before abort with error; minimum 2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `haddr` in 32, `hwrite` in 1, `htrans` in 2, `hsize` in 3, `hwdata` in 32: AHB-Lite master request.
- `hrdata` out 32, `hready` out 1, `hresp` out 1: AHB-Lite response.
- `sbus_addr` in 32, `sbus_write` in 1, `sbus_size` in 2, `sbus_wdata` in 32, `sbus_vld` in 1: debug sbus request.
- `sbus_rdy` out 1, `sbus_err` out 1, `sbus_rdata` out 32: debug sbus response.
- `core_cyc`, `core_stb`, `core_we` out 1; `core_addr` out 32; `core_sel` out 4; `core_data_out` out 32: Wishbone master.
- `core_data_in` in 32, `core_ack` in 1: Wishbone slave response.

## Operation
- Reset values: `hready`=1, `hresp`=0, `hrdata`=0, `sbus_rdy`=0, `sbus_err`=0, `sbus_rdata`=0, all `core_*` outputs 0; FSM IDLE; both pending flags cleared; `last_grant`=AHB.
- AHB capture: any cycle with `hready`=1 and `htrans[1]`=1 latches `haddr/hwrite/hsize`, sets `ahb_pend`, drives `hready`=0 next cycle. `hwdata` sampled when the Wishbone cycle is issued (valid throughout data phase).
- sbus request: `sbus_vld`=1 is pending; master holds request fields stable until `sbus_rdy`.
- FSM states: IDLE, BUS, ERR1, ERR2.
  - IDLE: if only one request pending, grant it; if both, grant the one not equal to `last_grant`. On grant update `last_grant`; if access invalid go ERR1, else assert `core_cyc`=`core_stb`=1 and go BUS.
  - BUS: hold `core_*` stable; on `core_ack`=1 deassert `core_cyc/stb` next cycle, deliver response, return IDLE. Timeout counter reaching `TIMEOUT_CYCLES` deasserts `core_cyc/stb` and goes ERR1.
  - ERR1/ERR2: AHB owner gets two-cycle error (ERR1: `hresp`=1, `hready`=0; ERR2: `hresp`=1, `hready`=1). sbus owner gets `sbus_rdy`=`sbus_err`=1 for one cycle in ERR1, then IDLE directly.
- Invalid access: size 1 with addr[0]=1; size 2 with addr[1:0]≠0; AHB `hsize`>2. No Wishbone cycle issued.
- Address/sel: `core_addr`={addr[31:2],2'b00}. Byte: `core_sel`=1<<addr[1:0]; half: addr[1]?4'b1100:4'b0011; word: 4'b1111.
- Write data replicated: byte 4×, half 2×, word unchanged. Reads return full `core_data_in` word unshifted on `hrdata`/`sbus_rdata`.
- Responses: AHB: `hready`=1, `hresp`=0, `hrdata` valid for one cycle. sbus: `sbus_rdy`=1 one cycle with `sbus_rdata`, `sbus_err`=0.
- `core_we`=owner's write flag; `core_sel` driven on reads too.

## Timing
- One Wishbone transaction outstanding; no AHB pipelining beyond the one captured address.
- Grant cycle G (IDLE sees pending); `core_cyc/stb` high G+1; ack sampled at cycle K; response pulse and `core_cyc/stb` low at K+1. Minimum AHB read: address phase cycle 0, `hready`=1 with data at cycle 3 (ack in cycle 2).
- AHB address presented in the response cycle (`hready`=1) is captured; back-to-back transfers need no idle cycle on AHB.
- Simultaneous AHB capture and `sbus_vld` in IDLE: round-robin; loser stays pending, `hready` stays 0 / `sbus_rdy` stays 0 until served.
- `core_ack` outside BUS is ignored. `sbus_vld` dropping before `sbus_rdy` is a protocol violation; behaviour undefined.
- Timeout counter cleared on entry to BUS; error issued at exactly `TIMEOUT_CYCLES` cycles of BUS without ack.
- Async reset mid-transaction: all outputs return to reset values immediately; pending requests discarded.

## Test plan
- AHB word read 0x0000_0040, ack after 2 wait cycles returning 0xDEAD_BEEF -> `core_sel`=4'hF, `core_we`=0, `hrdata`=0xDEAD_BEEF with `hready`=1 one cycle after ack.
- AHB byte write addr 0x103, hwdata 0x0000_00A5 -> `core_addr`=0x100, `core_sel`=4'b1000, `core_data_out`=0xA5A5_A5A5.
- AHB capture and `sbus_vld` same cycle after reset -> sbus served first, then AHB; next tie served AHB first.
- sbus half read addr 0x201 -> no `core_cyc`, `sbus_rdy`=`sbus_err`=1 one cycle; AHB word at 0x002 -> `hresp`=1 two cycles, `hready` 0 then 1.
- TIMEOUT_CYCLES=8, never ack -> `core_cyc` drops after 8 BUS cycles, AHB error response follows.
- Assert `rst_n`=0 during BUS -> `core_cyc`=0, `hready`=1 immediately; after release, new read completes normally.
